// File: rtl/simple_pkg.sv
// Shared definitions for the ALU writeback stage: branch condition codes,
// SZCV flag bit positions, register-file address width and the stage FSM states.
package simple_pkg;

    localparam int unsigned RADDR_W = 3;

    // Branch condition codes carried in the instruction's cond field.
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_B   = 3'b111;

    // Bit positions inside the 4-bit SZCV flag vector.
    localparam int unsigned FLAG_S = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: decides whether a branch with the
// given condition code is taken against a SZCV flag vector.
module branch_cond_eval
    import simple_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic s_flag;
    logic z_flag;
    logic v_flag;
    logic lt;
    logic unused_c;

    assign s_flag   = flags[FLAG_S];
    assign z_flag   = flags[FLAG_Z];
    assign v_flag   = flags[FLAG_V];
    // Signed less-than after a compare.
    assign lt       = s_flag ^ v_flag;
    // Carry does not take part in any supported condition.
    assign unused_c = flags[FLAG_C];

    // Decode the condition code; unassigned codes are never taken.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_BE:  taken = z_flag;
            COND_BLT: taken = lt;
            COND_BLE: taken = z_flag | lt;
            COND_BNE: taken = ~z_flag;
            COND_B:   taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: one-entry buffer after the ALU holding the result and
// per-instruction control, the architectural SZCV flag register, branch
// resolution against those flags, register-file write port and HLT handling.
// Optional bypass outputs (fwd_valid/fwd_addr/fwd_data) are built when the
// macro ALU_WB_FWD_EN is defined.
module alu_writeback_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_res,
    input  logic [3:0]         alu_szcv,
    input  logic [RADDR_W-1:0] rd,
    input  logic               wb_en,
    input  logic               flag_en,
    input  logic               is_branch,
    input  logic [2:0]         cond,
    input  logic [DATA_W-1:0]  br_target,
    input  logic               is_halt,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [3:0]         flags,
    output logic               br_taken,
    output logic [DATA_W-1:0]  br_pc,
    output logic               halted
`ifdef ALU_WB_FWD_EN
    ,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]  fwd_data
`endif
);

    import simple_pkg::*;

    wb_state_e state;
    logic      accept;
    logic      cond_true;

    // Branches resolve against the flags as they stand before this instruction.
    branch_cond_eval u_branch_cond_eval (
        .flags (flags),
        .cond  (cond),
        .taken (cond_true)
    );

    assign in_ready = (state == RUN) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign halted   = (state == HALTED);

`ifdef ALU_WB_FWD_EN
    // Bypass view of the pending write, driven only from the entry register.
    assign fwd_valid = out_valid && rf_we;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;
`endif

    // Entry register, flag register and RUN/HALTED state; flush outranks accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            out_valid <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            flags     <= 4'b0000;
            br_taken  <= 1'b0;
            br_pc     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            rf_we     <= 1'b0;
            br_taken  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rf_wdata  <= alu_res;
            rf_waddr  <= rd;
            rf_we     <= wb_en && !is_branch && !is_halt;
            br_pc     <= br_target;
            br_taken  <= is_branch && cond_true;
            if (flag_en) begin
                flags <= alu_szcv;
            end
            if (is_halt) begin
                state <= HALTED;
            end
        end else if (out_valid && out_ready) begin
            // Entry consumed with nothing behind it; data fields keep their values.
            out_valid <= 1'b0;
            rf_we     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed vector table, hand
// sequences for stall/flush/halt/reset, then randomized traffic against a
// transaction-level reference model.
module tb_alu_writeback_stage;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned RADDR_W = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  alu_res;
    logic [3:0]         alu_szcv;
    logic [RADDR_W-1:0] rd;
    logic               wb_en;
    logic               flag_en;
    logic               is_branch;
    logic [2:0]         cond;
    logic [DATA_W-1:0]  br_target;
    logic               is_halt;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [3:0]         flags;
    logic               br_taken;
    logic [DATA_W-1:0]  br_pc;
    logic               halted;
`ifdef ALU_WB_FWD_EN
    logic               fwd_valid;
    logic [RADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0]  fwd_data;
`endif

    alu_writeback_stage #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_res   (alu_res),
        .alu_szcv  (alu_szcv),
        .rd        (rd),
        .wb_en     (wb_en),
        .flag_en   (flag_en),
        .is_branch (is_branch),
        .cond      (cond),
        .br_target (br_target),
        .is_halt   (is_halt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .flags     (flags),
        .br_taken  (br_taken),
        .br_pc     (br_pc),
        .halted    (halted)
`ifdef ALU_WB_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit               valid;
        bit               we;
        bit [RADDR_W-1:0] waddr;
        bit [DATA_W-1:0]  wdata;
        bit               taken;
        bit [DATA_W-1:0]  pc;
    } entry_t;

    entry_t  m_e;
    bit [3:0] m_flags;
    bit       m_halted;

    function automatic bit cond_holds(input bit [3:0] f, input bit [2:0] c);
        bit s = f[3];
        bit z = f[2];
        bit v = f[0];
        case (c)
            3'd0:    return z;
            3'd1:    return s != v;
            3'd2:    return z || (s != v);
            3'd3:    return !z;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_in_ready();
        return !m_halted && !flush && (!m_e.valid || out_ready);
    endfunction

    task automatic model_step();
        if (rst) begin
            m_e      = '{default: 0};
            m_flags  = 4'b0;
            m_halted = 1'b0;
        end else if (flush) begin
            m_e.valid = 1'b0;
            m_e.we    = 1'b0;
            m_e.taken = 1'b0;
        end else if (in_valid && m_in_ready()) begin
            m_e.valid = 1'b1;
            m_e.we    = wb_en && !is_branch && !is_halt;
            m_e.waddr = rd;
            m_e.wdata = alu_res;
            m_e.taken = is_branch && cond_holds(m_flags, cond);
            m_e.pc    = br_target;
            if (flag_en) m_flags = alu_szcv;
            if (is_halt) m_halted = 1'b1;
        end else if (m_e.valid && out_ready) begin
            m_e.valid = 1'b0;
            m_e.we    = 1'b0;
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 0; alu_res = '0; alu_szcv = '0; rd = '0; wb_en = 0; flag_en = 0;
        is_branch = 0; cond = '0; br_target = '0; is_halt = 0; flush = 0; out_ready = 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_e.valid);
        chk({tag, ".rf_we"}, rf_we, m_e.we);
        chk({tag, ".rf_waddr"}, rf_waddr, m_e.waddr);
        chk({tag, ".rf_wdata"}, rf_wdata, m_e.wdata);
        chk({tag, ".flags"}, flags, m_flags);
        chk({tag, ".br_taken"}, br_taken, m_e.taken);
        chk({tag, ".br_pc"}, br_pc, m_e.pc);
        chk({tag, ".halted"}, halted, m_halted);
`ifdef ALU_WB_FWD_EN
        chk({tag, ".fwd_valid"}, fwd_valid, m_e.valid && m_e.we);
        chk({tag, ".fwd_addr"}, fwd_addr, m_e.waddr);
        chk({tag, ".fwd_data"}, fwd_data, m_e.wdata);
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] res;
        logic [3:0]  szcv;
        logic [2:0]  rd;
        logic        wb;
        logic        fe;
        logic        br;
        logic [2:0]  cnd;
        logic [15:0] tgt;
        logic        e_we;
        logic [2:0]  e_waddr;
        logic [15:0] e_wdata;
        logic [3:0]  e_flags;
        logic        e_taken;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{16'h1234, 4'b0000, 3'd5, 1, 0, 0, 3'd0, 16'h0000, 1, 3'd5, 16'h1234, 4'b0000, 0, 16'h0000};
        vecs[1]  = '{16'h0000, 4'b0100, 3'd1, 0, 1, 0, 3'd0, 16'h0000, 0, 3'd1, 16'h0000, 4'b0100, 0, 16'h0000};
        vecs[2]  = '{16'h0000, 4'b1111, 3'd0, 0, 0, 1, 3'd0, 16'h0040, 0, 3'd0, 16'h0000, 4'b0100, 1, 16'h0040};
        vecs[3]  = '{16'h0000, 4'b0000, 3'd0, 0, 0, 1, 3'd3, 16'h0080, 0, 3'd0, 16'h0000, 4'b0100, 0, 16'h0080};
        vecs[4]  = '{16'h0007, 4'b1000, 3'd2, 1, 1, 0, 3'd0, 16'h0000, 1, 3'd2, 16'h0007, 4'b1000, 0, 16'h0000};
        vecs[5]  = '{16'h0000, 4'b0000, 3'd0, 0, 0, 1, 3'd1, 16'h0100, 0, 3'd0, 16'h0000, 4'b1000, 1, 16'h0100};
        vecs[6]  = '{16'h0000, 4'b0000, 3'd0, 0, 0, 1, 3'd2, 16'h0104, 0, 3'd0, 16'h0000, 4'b1000, 1, 16'h0104};
        vecs[7]  = '{16'h0000, 4'b0000, 3'd0, 0, 0, 1, 3'd0, 16'h0108, 0, 3'd0, 16'h0000, 4'b1000, 0, 16'h0108};
        vecs[8]  = '{16'h0000, 4'b0000, 3'd0, 0, 0, 1, 3'd4, 16'h0110, 0, 3'd0, 16'h0000, 4'b1000, 0, 16'h0110};
        vecs[9]  = '{16'h0000, 4'b0000, 3'd0, 0, 0, 1, 3'd7, 16'h0120, 0, 3'd0, 16'h0000, 4'b1000, 1, 16'h0120};
        // Branch carrying flag_en resolves on the old flags (Z=0 here).
        vecs[10] = '{16'h0000, 4'b0100, 3'd0, 0, 1, 1, 3'd0, 16'h0130, 0, 3'd0, 16'h0000, 4'b0100, 0, 16'h0130};
        vecs[11] = '{16'h0000, 4'b0000, 3'd0, 0, 0, 1, 3'd0, 16'h0140, 0, 3'd0, 16'h0000, 4'b0100, 1, 16'h0140};
        vecs[12] = '{16'h5555, 4'b0000, 3'd6, 1, 0, 1, 3'd7, 16'h0200, 0, 3'd6, 16'h5555, 4'b0100, 1, 16'h0200};
    end

    initial begin
        idle_inputs();
        rst = 1;
        m_e = '{default: 0};
        m_flags = 0;
        m_halted = 0;
        clk_edge();
        clk_edge();
        rst = 0;

        // Reset state.
        settle();
        chk("reset.out_valid", out_valid, 0);
        chk("reset.rf_we", rf_we, 0);
        chk("reset.rf_waddr", rf_waddr, 0);
        chk("reset.rf_wdata", rf_wdata, 0);
        chk("reset.flags", flags, 0);
        chk("reset.br_taken", br_taken, 0);
        chk("reset.br_pc", br_pc, 0);
        chk("reset.halted", halted, 0);
        chk("reset.in_ready", in_ready, 1);

        // Table: back-to-back accepts with out_ready=1.
        for (int i = 0; i < 13; i++) begin
            in_valid = 1; out_ready = 1;
            alu_res = vecs[i].res; alu_szcv = vecs[i].szcv; rd = vecs[i].rd;
            wb_en = vecs[i].wb; flag_en = vecs[i].fe; is_branch = vecs[i].br;
            cond = vecs[i].cnd; br_target = vecs[i].tgt;
            settle();
            chk($sformatf("vec%0d.in_ready", i), in_ready, 1);
            clk_edge();
            chk($sformatf("vec%0d.out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d.rf_we", i), rf_we, vecs[i].e_we);
            chk($sformatf("vec%0d.rf_waddr", i), rf_waddr, vecs[i].e_waddr);
            chk($sformatf("vec%0d.rf_wdata", i), rf_wdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d.flags", i), flags, vecs[i].e_flags);
            chk($sformatf("vec%0d.br_taken", i), br_taken, vecs[i].e_taken);
            chk($sformatf("vec%0d.br_pc", i), br_pc, vecs[i].e_pc);
        end

        // Stall: hold an entry for three cycles, then drain with no new input.
        idle_inputs();
        in_valid = 1; alu_res = 16'hAAAA; rd = 3'd3; wb_en = 1;
        clk_edge();
        out_ready = 0; alu_res = 16'h9999; rd = 3'd7;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall.in_ready", in_ready, 0);
            clk_edge();
            chk("stall.out_valid", out_valid, 1);
            chk("stall.rf_we", rf_we, 1);
            chk("stall.rf_waddr", rf_waddr, 3);
            chk("stall.rf_wdata", rf_wdata, 16'hAAAA);
        end
        in_valid = 0; out_ready = 1;
        settle();
        chk("drain.commit_we", rf_we, 1);
        clk_edge();
        chk("drain.out_valid", out_valid, 0);
        chk("drain.rf_we", rf_we, 0);
        chk("drain.rf_wdata_held", rf_wdata, 16'hAAAA);

        // Flush with a held entry and a flag-setting input pending.
        idle_inputs();
        in_valid = 1; alu_res = 16'h0F0F; rd = 3'd4; wb_en = 1;
        clk_edge();
        out_ready = 0; flush = 1; flag_en = 1; alu_szcv = 4'b0001; alu_res = 16'h7777;
        settle();
        chk("flush.in_ready", in_ready, 0);
        clk_edge();
        chk("flush.out_valid", out_valid, 0);
        chk("flush.rf_we", rf_we, 0);
        chk("flush.br_taken", br_taken, 0);
        chk("flush.flags", flags, 4'b0100);
        chk("flush.rf_wdata", rf_wdata, 16'h0F0F);
        flush = 0; in_valid = 0;
        clk_edge();
        chk("flush.stays_empty", out_valid, 0);

        // Halt: entry presented without a write, then input locked until reset.
        idle_inputs();
        in_valid = 1; is_halt = 1; wb_en = 1; rd = 3'd1; alu_res = 16'h4321;
        clk_edge();
        chk("halt.out_valid", out_valid, 1);
        chk("halt.rf_we", rf_we, 0);
        chk("halt.halted", halted, 1);
        is_halt = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("halt.in_ready", in_ready, 0);
            clk_edge();
        end
        chk("halt.drained", out_valid, 0);
        chk("halt.still_halted", halted, 1);
        rst = 1;
        clk_edge();
        rst = 0;
        chk("halt.rst_halted", halted, 0);
        chk("halt.rst_flags", flags, 0);
        settle();
        chk("halt.rst_in_ready", in_ready, 1);

        // Reset while an entry is stalled.
        idle_inputs();
        in_valid = 1; alu_res = 16'h00AB; rd = 3'd2; wb_en = 1; flag_en = 1; alu_szcv = 4'b1010;
        clk_edge();
        out_ready = 0; in_valid = 0;
        clk_edge();
        rst = 1;
        clk_edge();
        rst = 0;
        chk("rststall.out_valid", out_valid, 0);
        chk("rststall.rf_we", rf_we, 0);
        chk("rststall.rf_wdata", rf_wdata, 0);
        chk("rststall.rf_waddr", rf_waddr, 0);
        chk("rststall.flags", flags, 0);

`ifdef ALU_WB_FWD_EN
        // Forwarding view of a pending write, held while stalled.
        idle_inputs();
        in_valid = 1; rd = 3'd2; alu_res = 16'hBEEF; wb_en = 1;
        clk_edge();
        in_valid = 0; out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            chk("fwd.valid", fwd_valid, 1);
            chk("fwd.addr", fwd_addr, 2);
            chk("fwd.data", fwd_data, 16'hBEEF);
            clk_edge();
        end
        out_ready = 1;
        clk_edge();
        chk("fwd.cleared", fwd_valid, 0);
`endif

        // Randomized traffic against the reference model.
        idle_inputs();
        rst = 1;
        clk_edge();
        rst = 0;
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 119) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            alu_res   = DATA_W'($urandom);
            alu_szcv  = 4'($urandom);
            rd        = RADDR_W'($urandom);
            wb_en     = 1'($urandom);
            flag_en   = ($urandom_range(0, 2) == 0);
            is_branch = ($urandom_range(0, 3) == 0);
            cond      = 3'($urandom);
            br_target = DATA_W'($urandom);
            is_halt   = ($urandom_range(0, 199) == 0);
            settle();
            chk("rand.in_ready", in_ready, m_in_ready());
            if (!rst && m_e.valid && m_e.we && out_ready) begin
                chk("rand.commit_addr", rf_waddr, m_e.waddr);
                chk("rand.commit_data", rf_wdata, m_e.wdata);
            end
            clk_edge();
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
